adder_result_checker: RTL and testbench

Synthesizable self-checking scoreboard for the parameterised N-bit ripple adder.
- Consumes the same stimulus the adder sees (a, b, cin) and computes the golden {cout, s} at the stimulus edge.
- Queues each golden result in order and compares it against the adder's result stream, counting passes and errors.
- Sits on the result side of the adder in simulation benches and on-board built-in self-test, replacing waveform inspection.

---
 rtl/adder_chk_pkg.sv | 30 +++
 rtl/chk_fifo.sv | 46 ++++
 rtl/adder_result_checker.sv | 153 +++++++++++++++
 tb/tb_adder_result_checker.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_chk_pkg.sv
// Shared types, defaults and helpers for the adder result checker.
package adder_chk_pkg;

    localparam int N_DEF     = 5;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 16;
    localparam int SAT_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Adds a small increment and clamps at max_val instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] val,
        input logic [1:0]       inc,
        input logic [SAT_W-1:0] max_val
    );
        logic [SAT_W:0] sum;
        sum = {1'b0, val} + {{(SAT_W - 1){1'b0}}, inc};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/chk_fifo.sv
// Synchronous show-ahead FIFO holding expected adder results, no bypass.
module chk_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Extra pointer MSB distinguishes full from empty when the indices coincide.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/adder_result_checker.sv
// Scoreboard for an N-bit ripple adder: golden sum, in-order compare, counters, FSM.
// Optional first-mismatch capture ports when ADDER_CHK_FIRST_ERR_EN is defined.
module adder_result_checker
    import adder_chk_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stim_valid,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             cin,
    input  logic             res_valid,
    input  logic [N-1:0]     s,
    input  logic             cout,
    input  logic             end_i,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             ovf,
    output logic             udf,
    output logic             done
`ifdef ADDER_CHK_FIRST_ERR_EN
    ,
    output logic [N:0]       first_err_exp,
    output logic [N:0]       first_err_got,
    output logic             first_err_valid
`endif
);

    localparam int               W       = N + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_ovf;
    logic             r_udf;
    logic             r_done;

    logic [W-1:0]     w_golden;
    logic [W-1:0]     w_head;
    logic [W-1:0]     w_got;
    logic             w_full;
    logic             w_empty;
    logic             w_stim_open;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    logic             w_miss;
    logic             w_pass;
    logic             w_ovf;
    logic             w_udf;
    logic             w_proto;
    logic [1:0]       w_err_inc;

    assign w_golden = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign w_got    = {cout, s};

    // Stimulus is only taken before end_i; results are taken until DONE.
    assign w_stim_open = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_pop       = res_valid && (r_state != ST_DONE) && !w_empty;
    assign w_udf       = res_valid && !w_pop;
    assign w_push_req  = stim_valid && w_stim_open;
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_ovf       = w_push_req && !w_push;
    assign w_proto     = stim_valid && !w_stim_open;
    assign w_miss      = w_pop && (w_head != w_got);
    assign w_pass      = w_pop && !w_miss;
    assign w_err_inc   = {1'b0, w_miss} + {1'b0, w_ovf} + {1'b0, w_udf} + {1'b0, w_proto};

    chk_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_golden),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // NOTE: next state defaults to the current state first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (end_i) w_state_nxt = ST_DONE;
                      else if (stim_valid) w_state_nxt = ST_RUN;
            ST_RUN:   if (end_i) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_empty && !w_push) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mismatch <= 1'b0;
            r_pass_cnt <= '0;
            r_err_cnt  <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mismatch <= w_miss;
            r_pass_cnt <= CNT_W'(sat_add(SAT_W'(r_pass_cnt), {1'b0, w_pass}, SAT_W'(CNT_MAX)));
            r_err_cnt  <= CNT_W'(sat_add(SAT_W'(r_err_cnt), w_err_inc, SAT_W'(CNT_MAX)));
            r_ovf      <= r_ovf | w_ovf;
            r_udf      <= r_udf | w_udf;
            r_done     <= (w_state_nxt == ST_DONE);
        end
    end

    assign mismatch = r_mismatch;
    assign pass_cnt = r_pass_cnt;
    assign err_cnt  = r_err_cnt;
    assign ovf      = r_ovf;
    assign udf      = r_udf;
    assign done     = r_done;

`ifdef ADDER_CHK_FIRST_ERR_EN
    logic [W-1:0] r_fe_exp;
    logic [W-1:0] r_fe_got;
    logic         r_fe_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fe_exp   <= '0;
            r_fe_got   <= '0;
            r_fe_valid <= 1'b0;
        end else if (w_miss && !r_fe_valid) begin
            r_fe_exp   <= w_head;
            r_fe_got   <= w_got;
            r_fe_valid <= 1'b1;
        end
    end

    assign first_err_exp   = r_fe_exp;
    assign first_err_got   = r_fe_got;
    assign first_err_valid = r_fe_valid;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker with a queue-based reference model.
module tb_adder_result_checker;

    localparam int N       = 5;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             stim_valid;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             cin;
    logic             res_valid;
    logic [N-1:0]     s;
    logic             cout;
    logic             end_i;
    logic             mismatch;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             ovf;
    logic             udf;
    logic             done;
`ifdef ADDER_CHK_FIRST_ERR_EN
    logic [N:0]       first_err_exp;
    logic [N:0]       first_err_got;
    logic             first_err_valid;
`endif

    adder_result_checker #(
        .N     (N),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stim_valid (stim_valid),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .res_valid  (res_valid),
        .s          (s),
        .cout       (cout),
        .end_i      (end_i),
        .mismatch   (mismatch),
        .pass_cnt   (pass_cnt),
        .err_cnt    (err_cnt),
        .ovf        (ovf),
        .udf        (udf),
        .done       (done)
`ifdef ADDER_CHK_FIRST_ERR_EN
        ,
        .first_err_exp   (first_err_exp),
        .first_err_got   (first_err_got),
        .first_err_valid (first_err_valid)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 idle, 1 running, 2 draining, 3 finished.
    int         m_phase;
    logic [N:0] m_q[$];
    int         m_pass;
    int         m_err;
    bit         m_mis;
    bit         m_ovf;
    bit         m_udf;
    bit         m_done;
    logic [N:0] m_fe_exp;
    logic [N:0] m_fe_got;
    bit         m_fe_valid;

    function automatic logic [N:0] gold(input logic [N-1:0] x, input logic [N-1:0] y,
                                        input logic c);
        int t;
        t = int'(x) + int'(y) + int'(c);
        return t[N:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase    = 0;
        m_q.delete();
        m_pass     = 0;
        m_err      = 0;
        m_mis      = 0;
        m_ovf      = 0;
        m_udf      = 0;
        m_done     = 0;
        m_fe_exp   = '0;
        m_fe_got   = '0;
        m_fe_valid = 0;
    endtask

    task automatic model_step();
        int         nphase;
        int         einc;
        int         sz0;
        bit         mis;
        logic [N:0] expv;
        nphase = m_phase;
        einc   = 0;
        mis    = 0;
        sz0    = m_q.size();
        if (res_valid) begin
            if (m_phase == 3 || m_q.size() == 0) begin
                m_udf = 1;
                einc++;
            end else begin
                expv = m_q.pop_front();
                if (expv !== {cout, s}) begin
                    mis = 1;
                    einc++;
                    if (!m_fe_valid) begin
                        m_fe_exp   = expv;
                        m_fe_got   = {cout, s};
                        m_fe_valid = 1;
                    end
                end else if (m_pass < CNT_MAX) begin
                    m_pass++;
                end
            end
        end
        if (stim_valid) begin
            if (m_phase >= 2) einc++;
            else if (m_q.size() >= DEPTH) begin
                m_ovf = 1;
                einc++;
            end else m_q.push_back(gold(a, b, cin));
        end
        case (m_phase)
            0: if (end_i) nphase = 3; else if (stim_valid) nphase = 1;
            1: if (end_i) nphase = 2;
            2: if (sz0 == 0) nphase = 3;
            default: nphase = 3;
        endcase
        m_err   = (m_err + einc > CNT_MAX) ? CNT_MAX : m_err + einc;
        m_mis   = mis;
        m_phase = nphase;
        m_done  = (nphase == 3);
    endtask

    task automatic compare_all();
        check("mismatch", 32'(mismatch), 32'(m_mis));
        check("pass_cnt", 32'(pass_cnt), 32'(m_pass));
        check("err_cnt",  32'(err_cnt),  32'(m_err));
        check("ovf",      32'(ovf),      32'(m_ovf));
        check("udf",      32'(udf),      32'(m_udf));
        check("done",     32'(done),     32'(m_done));
`ifdef ADDER_CHK_FIRST_ERR_EN
        check("fe_valid", 32'(first_err_valid), 32'(m_fe_valid));
        if (m_fe_valid) begin
            check("fe_exp", 32'(first_err_exp), 32'(m_fe_exp));
            check("fe_got", 32'(first_err_got), 32'(m_fe_got));
        end
`endif
    endtask

    task automatic clear_inputs();
        stim_valid = 0; a = '0; b = '0; cin = 0;
        res_valid = 0; s = '0; cout = 0; end_i = 0;
    endtask

    // One clock cycle: drive, let the edge happen, advance the model, compare.
    task automatic cyc(input bit sv, input logic [N-1:0] ia, input logic [N-1:0] ib,
                       input bit ic, input bit rv, input logic [N:0] r, input bit e);
        stim_valid = sv; a = ia; b = ib; cin = ic;
        res_valid = rv; {cout, s} = r; end_i = e;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        clear_inputs();
    endtask

    task automatic idle_cyc();
        cyc(0, '0, '0, 0, 0, '0, 0);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1;
        model_reset();
        #3;
        compare_all();
        check("gold_pin_a", 32'(gold(5'b10101, 5'b01010, 1'b0)), 32'h1f);
        check("gold_pin_b", 32'(gold(5'b11111, 5'b00001, 1'b1)), 32'h21);
        @(negedge clk);
        rst = 0;

        // Three good beats, results one cycle behind, then end of stimulus.
        cyc(1, 5'b10101, 5'b01010, 0, 0, '0, 0);
        cyc(1, 5'b11111, 5'b00001, 1, 1, 6'b011111, 0);
        cyc(1, 5'b00100, 5'b00111, 0, 1, 6'b100001, 0);
        cyc(0, '0, '0, 0, 1, 6'b001011, 0);
        cyc(0, '0, '0, 0, 0, '0, 1);
        idle_cyc();
        check("t1_pass", 32'(pass_cnt), 32'd3);
        check("t1_err",  32'(err_cnt),  32'd0);
        check("t1_done", 32'(done),     32'd1);

        // Wrong sum returned.
        do_reset();
        cyc(1, 5'b10101, 5'b01010, 0, 0, '0, 0);
        cyc(0, '0, '0, 0, 1, 6'b011110, 0);
        check("t2_mismatch", 32'(mismatch), 32'd1);
        check("t2_err",      32'(err_cnt),  32'd1);
`ifdef ADDER_CHK_FIRST_ERR_EN
        check("t2_fe_exp", 32'(first_err_exp), 32'h1f);
        check("t2_fe_got", 32'(first_err_got), 32'h1e);
`endif
        idle_cyc();

        // Overflow, then push+pop while full, then drain past empty.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 5'(i), '0, 0, 0, '0, 0);
        check("t3_ovf", 32'(ovf),     32'd1);
        check("t3_err", 32'(err_cnt), 32'd1);
        cyc(1, 5'd5, '0, 0, 1, 6'd0, 0);
        check("t3_full_pp_err", 32'(err_cnt), 32'd1);
        cyc(0, '0, '0, 0, 1, 6'd1, 0);
        cyc(0, '0, '0, 0, 1, 6'd2, 0);
        cyc(0, '0, '0, 0, 1, 6'd3, 0);
        cyc(0, '0, '0, 0, 1, 6'd5, 0);
        cyc(0, '0, '0, 0, 1, 6'd0, 0);
        check("t3_pass", 32'(pass_cnt), 32'd5);
        check("t3_udf",  32'(udf),      32'd1);
        check("t3_err2", 32'(err_cnt),  32'd2);

        // Result with nothing queued.
        do_reset();
        cyc(0, '0, '0, 0, 1, 6'd0, 0);
        check("t4_udf",  32'(udf),      32'd1);
        check("t4_err",  32'(err_cnt),  32'd1);
        check("t4_pass", 32'(pass_cnt), 32'd0);

        // Reset while entries are still queued.
        do_reset();
        cyc(1, 5'd1, '0, 0, 0, '0, 0);
        cyc(1, 5'd2, '0, 0, 1, 6'd1, 0);
        cyc(1, 5'd3, '0, 0, 0, '0, 0);
        do_reset();
        check("t5_pass_rst", 32'(pass_cnt), 32'd0);
        cyc(0, '0, '0, 0, 1, 6'd2, 0);
        check("t5_udf", 32'(udf),     32'd1);
        check("t5_err", 32'(err_cnt), 32'd1);

        // Pass counter saturation, then protocol errors after end.
        do_reset();
        for (int i = 0; i <= 16; i++)
            cyc(1, 5'(i), '0, 0, (i > 0), 6'(i - 1), 0);
        cyc(0, '0, '0, 0, 1, 6'd16, 0);
        check("t6_pass_sat", 32'(pass_cnt), 32'd15);
        check("t6_err",      32'(err_cnt),  32'd0);
        cyc(0, '0, '0, 0, 0, '0, 1);
        cyc(1, 5'd7, '0, 0, 0, '0, 0);
        cyc(0, '0, '0, 0, 1, 6'd7, 0);
        check("t6_err2", 32'(err_cnt), 32'd2);
        check("t6_udf",  32'(udf),     32'd1);
        check("t6_done", 32'(done),    32'd1);
        idle_cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
